// File: rtl/cpu_pkg.sv
// Shared encodings, ALU operations and pipeline-register layouts for cpu_core.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RIDX  = 5;
    localparam int unsigned NREGS = 32;

    localparam logic [5:0] OPC_ALU1 = 6'b100000;
    localparam logic [5:0] OPC_ADDI = 6'b101000;
    localparam logic [5:0] OPC_ORI  = 6'b101100;
    localparam logic [5:0] OPC_XORI = 6'b101011;
    localparam logic [5:0] OPC_MOVI = 6'b100010;
    localparam logic [5:0] OPC_LWI  = 6'b000010;
    localparam logic [5:0] OPC_SWI  = 6'b001010;
    localparam logic [5:0] OPC_BR   = 6'b100110;
    localparam logic [5:0] OPC_J    = 6'b100100;

    localparam logic [4:0] SUB_ADD   = 5'b00000;
    localparam logic [4:0] SUB_SUB   = 5'b00001;
    localparam logic [4:0] SUB_AND   = 5'b00010;
    localparam logic [4:0] SUB_XOR   = 5'b00011;
    localparam logic [4:0] SUB_OR    = 5'b00100;
    localparam logic [4:0] SUB_SLLI  = 5'b01000;
    localparam logic [4:0] SUB_SRLI  = 5'b01001;
    localparam logic [4:0] SUB_ROTRI = 5'b01011;

    // SRLI r0,r0,0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h4000_0009;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_OR,
        ALU_SLL,
        ALU_SRL,
        ALU_ROTR,
        ALU_PASSB
    } alu_op_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

    typedef struct packed {
        logic            we;
        alu_op_e         op;
        logic            use_imm;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rt;
        logic [RIDX-1:0] ra;
        logic [RIDX-1:0] rb;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] t;
        logic            is_load;
        logic            is_store;
        logic            is_branch;
        logic            br_ne;
        logic            is_jump;
        logic [XLEN-1:0] target;
    } id_ex_t;

    typedef struct packed {
        logic            we;
        logic [RIDX-1:0] rd;
        logic [XLEN-1:0] result;
        logic            is_load;
        logic            is_store;
        logic [XLEN-1:0] sdata;
    } ex_mem_t;

    typedef struct packed {
        logic            we;
        logic [RIDX-1:0] rd;
        logic [XLEN-1:0] data;
    } mem_wb_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shift amounts come from b[4:0].
module alu
    import cpu_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result_c
);

    logic [4:0] sh;

    assign sh = b[4:0];

    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:   result_c = a + b;
            ALU_SUB:   result_c = a - b;
            ALU_AND:   result_c = a & b;
            ALU_XOR:   result_c = a ^ b;
            ALU_OR:    result_c = a | b;
            ALU_SLL:   result_c = a << sh;
            ALU_SRL:   result_c = a >> sh;
            // a << 32 is zero, so a rotate by 0 degenerates to a
            ALU_ROTR:  result_c = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
            ALU_PASSB: result_c = b;
            default:   result_c = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data RAM: asynchronous read, write on the rising edge.
module data_memory
    import cpu_pkg::*;
#(
    parameter int unsigned DM_WORDS = 64
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DM_WORDS)-1:0] addr,
    input  logic [XLEN-1:0]             wdata,
    output logic [XLEN-1:0]             rdata_c
);

    logic [XLEN-1:0] mem_data [DM_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem_data[addr] <= wdata;
        end
    end

    assign rdata_c = mem_data[addr];

endmodule

// File: rtl/inst_memory.sv
// Instruction ROM; contents are placed by the environment, unloaded words read as NOP.
module inst_memory
    import cpu_pkg::*;
#(
    parameter int unsigned IM_WORDS = 64
) (
    input  logic [$clog2(IM_WORDS)-1:0] addr,
    output logic [XLEN-1:0]             instr_c
);

    logic [XLEN-1:0] mem_data [IM_WORDS] = '{default: NOP_INSN};

    assign instr_c = mem_data[addr];

endmodule

// File: rtl/regfile.sv
// 32x32 register file, three read ports with same-cycle write-through.
module regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RIDX-1:0] waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RIDX-1:0] raddr_a,
    input  logic [RIDX-1:0] raddr_b,
    input  logic [RIDX-1:0] raddr_t,
    output logic [XLEN-1:0] rdata_a_c,
    output logic [XLEN-1:0] rdata_b_c,
    output logic [XLEN-1:0] rdata_t_c
);

    logic [XLEN-1:0] rw_reg [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rw_reg[i] <= '0;
            end
        end else if (we) begin
            rw_reg[waddr] <= wdata;
        end
    end

    assign rdata_a_c = (we && waddr == raddr_a) ? wdata : rw_reg[raddr_a];
    assign rdata_b_c = (we && waddr == raddr_b) ? wdata : rw_reg[raddr_b];
    assign rdata_t_c = (we && waddr == raddr_t) ? wdata : rw_reg[raddr_t];

endmodule

// File: rtl/cpu_core.sv
// Five-stage in-order NDS32-subset pipeline with forwarding, load-use stall and EX-resolved branches.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned IM_WORDS = 64,
    parameter int unsigned DM_WORDS = 64
) (
    input logic clk,
    input logic rst
);

    localparam int unsigned IM_AW = $clog2(IM_WORDS);
    localparam int unsigned DM_AW = $clog2(DM_WORDS);

    logic [XLEN-1:0] pc;
    if_id_t          if_id;
    id_ex_t          id_ex;
    ex_mem_t         ex_mem;
    mem_wb_t         mem_wb;

    logic [XLEN-1:0] fetch_instr;
    logic [XLEN-1:0] ins;
    id_ex_t          dec;
    logic            use_ra, use_rb, use_rt;
    logic [XLEN-1:0] rf_a, rf_b, rf_t;
    logic            load_use;
    logic [XLEN-1:0] fa, fb, ft, alu_y, dm_rdata;
    logic            taken;
    logic            dm_we;

    inst_memory #(.IM_WORDS(IM_WORDS)) inst_memory (
        .addr    (pc[IM_AW+1:2]),
        .instr_c (fetch_instr)
    );

    regfile regfile1 (
        .clk       (clk),
        .rst       (rst),
        .we        (mem_wb.we),
        .waddr     (mem_wb.rd),
        .wdata     (mem_wb.data),
        .raddr_a   (ins[19:15]),
        .raddr_b   (ins[14:10]),
        .raddr_t   (ins[24:20]),
        .rdata_a_c (rf_a),
        .rdata_b_c (rf_b),
        .rdata_t_c (rf_t)
    );

    data_memory #(.DM_WORDS(DM_WORDS)) data_memory (
        .clk     (clk),
        .we      (dm_we),
        .addr    (ex_mem.result[DM_AW+1:2]),
        .wdata   (ex_mem.sdata),
        .rdata_c (dm_rdata)
    );

    alu alu (
        .op       (id_ex.op),
        .a        (fa),
        .b        (fb),
        .result_c (alu_y)
    );

    assign ins = if_id.instr;

    // ID: decode into ID/EX payload; unrecognised encodings leave we/mem/branch clear (NOP)
    always_comb begin
        dec        = '0;
        use_ra     = 1'b0;
        use_rb     = 1'b0;
        use_rt     = 1'b0;
        dec.op     = ALU_ADD;
        dec.rt     = ins[24:20];
        dec.ra     = ins[19:15];
        dec.rb     = ins[14:10];
        dec.a      = rf_a;
        dec.b      = rf_b;
        dec.t      = rf_t;
        dec.target = if_id.pc + {{17{ins[13]}}, ins[13:0], 1'b0};
        if (!ins[31]) begin
            case (ins[30:25])
                OPC_ALU1: begin
                    dec.we = 1'b1;
                    use_ra = 1'b1;
                    case (ins[4:0])
                        SUB_ADD: begin dec.op = ALU_ADD; use_rb = 1'b1; end
                        SUB_SUB: begin dec.op = ALU_SUB; use_rb = 1'b1; end
                        SUB_AND: begin dec.op = ALU_AND; use_rb = 1'b1; end
                        SUB_XOR: begin dec.op = ALU_XOR; use_rb = 1'b1; end
                        SUB_OR:  begin dec.op = ALU_OR;  use_rb = 1'b1; end
                        SUB_SLLI, SUB_SRLI, SUB_ROTRI: begin
                            dec.op      = (ins[4:0] == SUB_SLLI) ? ALU_SLL :
                                          (ins[4:0] == SUB_SRLI) ? ALU_SRL : ALU_ROTR;
                            dec.use_imm = 1'b1;
                            dec.imm     = XLEN'(ins[14:10]);
                        end
                        default: begin
                            dec.we = 1'b0;
                            use_ra = 1'b0;
                        end
                    endcase
                end
                OPC_ADDI, OPC_ORI, OPC_XORI: begin
                    dec.we      = 1'b1;
                    use_ra      = 1'b1;
                    dec.use_imm = 1'b1;
                    dec.op      = (ins[30:25] == OPC_ADDI) ? ALU_ADD :
                                  (ins[30:25] == OPC_ORI)  ? ALU_OR  : ALU_XOR;
                    dec.imm     = (ins[30:25] == OPC_ADDI) ? {{17{ins[14]}}, ins[14:0]}
                                                           : {17'b0, ins[14:0]};
                end
                OPC_MOVI: begin
                    dec.we      = 1'b1;
                    dec.op      = ALU_PASSB;
                    dec.use_imm = 1'b1;
                    dec.imm     = {{12{ins[19]}}, ins[19:0]};
                end
                OPC_LWI, OPC_SWI: begin
                    dec.we       = (ins[30:25] == OPC_LWI);
                    dec.is_load  = (ins[30:25] == OPC_LWI);
                    dec.is_store = (ins[30:25] == OPC_SWI);
                    use_ra       = 1'b1;
                    use_rt       = (ins[30:25] == OPC_SWI);
                    dec.use_imm  = 1'b1;
                    dec.imm      = {{15{ins[14]}}, ins[14:0], 2'b00};
                end
                OPC_BR: begin
                    dec.is_branch = 1'b1;
                    dec.br_ne     = ins[14];
                    use_ra        = 1'b1;
                    use_rt        = 1'b1;
                end
                OPC_J: begin
                    dec.is_jump = !ins[24];
                    dec.target  = if_id.pc + {{7{ins[23]}}, ins[23:0], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign load_use = id_ex.is_load &&
                      ((use_ra && id_ex.rt == dec.ra) ||
                       (use_rb && id_ex.rt == dec.rb) ||
                       (use_rt && id_ex.rt == dec.rt));

    function automatic logic [XLEN-1:0] fwd(
        input logic [RIDX-1:0] r,
        input logic [XLEN-1:0] v,
        input logic            em_we,
        input logic [RIDX-1:0] em_rd,
        input logic [XLEN-1:0] em_val,
        input logic            mw_we,
        input logic [RIDX-1:0] mw_rd,
        input logic [XLEN-1:0] mw_val
    );
        if (em_we && em_rd == r) begin
            return em_val;
        end else if (mw_we && mw_rd == r) begin
            return mw_val;
        end
        return v;
    endfunction

    // EX: operand forwarding (EX/MEM over MEM/WB) and branch resolution
    always_comb begin
        fa    = fwd(id_ex.ra, id_ex.a, ex_mem.we, ex_mem.rd, ex_mem.result,
                    mem_wb.we, mem_wb.rd, mem_wb.data);
        ft    = fwd(id_ex.rt, id_ex.t, ex_mem.we, ex_mem.rd, ex_mem.result,
                    mem_wb.we, mem_wb.rd, mem_wb.data);
        fb    = id_ex.use_imm ? id_ex.imm :
                fwd(id_ex.rb, id_ex.b, ex_mem.we, ex_mem.rd, ex_mem.result,
                    mem_wb.we, mem_wb.rd, mem_wb.data);
        taken = id_ex.is_jump || (id_ex.is_branch && ((fa == ft) != id_ex.br_ne));
    end

    assign dm_we = ex_mem.is_store && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= '0;
            if_id  <= '{instr: NOP_INSN, pc: '0};
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            if (taken) begin
                pc    <= id_ex.target;
                if_id <= '{instr: NOP_INSN, pc: '0};
                id_ex <= '0;
            end else if (load_use) begin
                id_ex <= '0;
            end else begin
                pc    <= pc + XLEN'(4);
                if_id <= '{instr: fetch_instr, pc: pc};
                id_ex <= dec;
            end
            ex_mem <= '{we: id_ex.we, rd: id_ex.rt, result: alu_y,
                        is_load: id_ex.is_load, is_store: id_ex.is_store, sdata: ft};
            mem_wb <= '{we: ex_mem.we, rd: ex_mem.rd,
                        data: ex_mem.is_load ? dm_rdata : ex_mem.result};
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Directed programs for cpu_core; expected register/DM state is queued and checked by a monitor.
module tb_cpu_core;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cpu_core #(.IM_WORDS(64), .DM_WORDS(64)) dut (
        .clk (clk),
        .rst (rst)
    );

    typedef struct {
        bit          is_dm;
        int          idx;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prog[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          chk_en = 1'b0;
    exp_t        me;
    logic [31:0] act;

    localparam logic [31:0] NOP = 32'h4000_0009;

    function automatic logic [31:0] e_alu(input logic [4:0] sub, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {1'b0, 6'b100000, rt, ra, rb, 5'b00000, sub};
    endfunction

    function automatic logic [31:0] e_i15(input logic [5:0] opc, input logic [4:0] rt,
                                          input logic [4:0] ra, input logic [14:0] imm);
        return {1'b0, opc, rt, ra, imm};
    endfunction

    function automatic logic [31:0] e_movi(input logic [4:0] rt, input logic [19:0] imm);
        return {1'b0, 6'b100010, rt, imm};
    endfunction

    function automatic logic [31:0] e_br(input logic ne, input logic [4:0] rt,
                                         input logic [4:0] ra, input logic [13:0] imm);
        return {1'b0, 6'b100110, rt, ra, ne, imm};
    endfunction

    function automatic logic [31:0] e_j(input logic [23:0] imm);
        return {1'b0, 6'b100100, 1'b0, imm};
    endfunction

    // Monitor: drains the scoreboard against architectural state when a check is requested
    always @(negedge clk) begin
        if (chk_en) begin
            while (sb.size() > 0) begin
                me  = sb.pop_front();
                act = me.is_dm ? dut.data_memory.mem_data[me.idx[5:0]]
                               : dut.regfile1.rw_reg[me.idx[4:0]];
                checks++;
                if (act !== me.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", me.tag, act, me.val);
                end
            end
            chk_en = 1'b0;
        end
    end

    task automatic exp_reg(input int r, input logic [31:0] v, input string tag);
        exp_t e;
        e.is_dm = 1'b0; e.idx = r; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_dm(input int w, input logic [31:0] v, input string tag);
        exp_t e;
        e.is_dm = 1'b1; e.idx = w; e.val = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_now();
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        if (chk_en || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
            sb.delete();
            chk_en = 1'b0;
        end
    endtask

    task automatic load_in_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            dut.inst_memory.mem_data[i[5:0]] = (i < prog.size()) ? prog[i] : NOP;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_rst();
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        // forwarding chain, write timing and reset state
        prog = '{e_movi(5'd1, 20'd5), e_movi(5'd2, 20'd7), e_alu(5'b00000, 5'd3, 5'd1, 5'd2)};
        load_in_reset();
        exp_reg(1, 32'd0, "reset_r1"); exp_reg(31, 32'd0, "reset_r31");
        exp_dm(2, 32'd0, "reset_dm2");
        check_now();
        release_rst();
        run_to(4); exp_reg(1, 32'd0, "t1_r1_c4"); check_now();
        run_to(5); exp_reg(1, 32'd5, "t1_r1_c5"); check_now();
        run_to(20);
        exp_reg(2, 32'd7, "t1_r2"); exp_reg(3, 32'd12, "t1_r3");
        check_now();

        // ADDI sign extension, SUB, SLLI
        prog = '{e_movi(5'd1, 20'hFFFFD), e_i15(6'b101000, 5'd2, 5'd1, 15'd10),
                 e_alu(5'b00001, 5'd4, 5'd2, 5'd1), e_alu(5'b01000, 5'd5, 5'd2, 5'd4)};
        load_in_reset(); release_rst(); run_to(20);
        exp_reg(1, 32'hFFFF_FFFD, "t2_r1"); exp_reg(2, 32'd7, "t2_r2");
        exp_reg(4, 32'd10, "t2_r4");        exp_reg(5, 32'd112, "t2_r5");
        check_now();

        // store, load, load-use stall of exactly one cycle
        prog = '{e_movi(5'd1, 20'd99), e_i15(6'b001010, 5'd1, 5'd0, 15'd2),
                 e_i15(6'b000010, 5'd6, 5'd0, 15'd2), e_alu(5'b00000, 5'd7, 5'd6, 5'd6)};
        load_in_reset(); release_rst();
        run_to(8); exp_reg(6, 32'd99, "t3_r6_c8"); exp_reg(7, 32'd0, "t3_r7_c8"); check_now();
        run_to(9); exp_reg(7, 32'd198, "t3_r7_c9"); check_now();
        run_to(20); exp_dm(2, 32'd99, "t3_dm2"); check_now();

        // BEQ taken, then BNE not taken
        prog = '{e_movi(5'd1, 20'd1), e_br(1'b0, 5'd1, 5'd1, 14'd4),
                 e_movi(5'd2, 20'd55), e_movi(5'd3, 20'd66)};
        load_in_reset(); release_rst(); run_to(20);
        exp_reg(2, 32'd0, "t4_beq_r2"); exp_reg(3, 32'd66, "t4_beq_r3"); check_now();
        prog = '{e_movi(5'd1, 20'd1), e_br(1'b1, 5'd1, 5'd1, 14'd4),
                 e_movi(5'd2, 20'd55), e_movi(5'd3, 20'd66)};
        load_in_reset(); release_rst(); run_to(20);
        exp_reg(2, 32'd55, "t5_bne_r2"); exp_reg(3, 32'd66, "t5_bne_r3"); check_now();

        // J over two MOVIs
        prog = '{e_movi(5'd1, 20'd11), e_j(24'd6), e_movi(5'd2, 20'd22),
                 e_movi(5'd3, 20'd33), e_movi(5'd4, 20'd44)};
        load_in_reset(); release_rst(); run_to(20);
        exp_reg(1, 32'd11, "t6_r1"); exp_reg(2, 32'd0, "t6_r2");
        exp_reg(3, 32'd0, "t6_r3");  exp_reg(4, 32'd44, "t6_r4");
        check_now();

        // logic ops, shifts/rotate, zero-extended immediates, r0 as a general register, unlisted opcode
        prog = '{e_movi(5'd1, 20'hFFFF0), e_movi(5'd2, 20'h00012),
                 e_alu(5'b00010, 5'd3, 5'd1, 5'd2), e_alu(5'b00011, 5'd4, 5'd1, 5'd2),
                 e_alu(5'b00100, 5'd5, 5'd1, 5'd2), e_alu(5'b01001, 5'd6, 5'd1, 5'd4),
                 e_alu(5'b01011, 5'd7, 5'd2, 5'd4), e_i15(6'b101100, 5'd8, 5'd2, 15'h7F00),
                 e_i15(6'b101011, 5'd9, 5'd1, 15'h4000), e_i15(6'b101000, 5'd10, 5'd0, 15'h7FFF),
                 e_movi(5'd0, 20'd9), e_alu(5'b00000, 5'd11, 5'd0, 5'd0),
                 {1'b0, 6'b111111, 5'd12, 20'hFFFFF}};
        load_in_reset(); release_rst(); run_to(30);
        exp_reg(3, 32'h0000_0010, "t7_and");   exp_reg(4, 32'hFFFF_FFE2, "t7_xor");
        exp_reg(5, 32'hFFFF_FFF2, "t7_or");    exp_reg(6, 32'h0FFF_FFFF, "t7_srli");
        exp_reg(7, 32'h2000_0001, "t7_rotri"); exp_reg(8, 32'h0000_7F12, "t7_ori");
        exp_reg(9, 32'hFFFF_BFF0, "t7_xori");  exp_reg(10, 32'hFFFF_FFFF, "t7_addi_neg");
        exp_reg(0, 32'd9, "t7_r0");            exp_reg(11, 32'd18, "t7_r0_fwd");
        exp_reg(12, 32'd0, "t7_unlisted");
        check_now();

        // reset asserted mid-program, then restart from PC 0
        prog = '{e_movi(5'd1, 20'd1), e_movi(5'd2, 20'd2), e_movi(5'd3, 20'd3),
                 e_movi(5'd4, 20'd4), e_movi(5'd5, 20'd5), e_movi(5'd6, 20'd6),
                 e_i15(6'b001010, 5'd1, 5'd0, 15'd4), e_movi(5'd7, 20'd7)};
        load_in_reset(); release_rst();
        run_to(9); exp_reg(5, 32'd5, "t8_r5_c9"); exp_reg(6, 32'd0, "t8_r6_c9"); check_now();
        rst = 1'b0;
        @(posedge clk);
        for (int r = 1; r <= 6; r++) exp_reg(r, 32'd0, $sformatf("t8_rst_r%0d", r));
        exp_dm(4, 32'd0, "t8_rst_dm4");
        check_now();
        release_rst();
        run_to(4); exp_reg(1, 32'd0, "t8_re_r1_c4"); check_now();
        run_to(5); exp_reg(1, 32'd1, "t8_re_r1_c5"); check_now();
        run_to(25);
        exp_reg(6, 32'd6, "t8_re_r6"); exp_reg(7, 32'd7, "t8_re_r7");
        exp_dm(4, 32'd1, "t8_re_dm4");
        check_now();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
